mem_dump_sender: RTL
====================

MEM_DUMP_SENDER -- requirements
Module: mem_dump_sender

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 5, giving slot address width; it SHALL be between 1 and 8.
REQ-002 The module SHALL have parameter SLOT_SIZE, default 32, giving slot width in bits; it SHALL be a multiple of 8.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port i_start, input, 1 bit: dump request.
REQ-006 The module SHALL have port i_bus_debug, input, 2**ADDR_SIZE*SLOT_SIZE bits: flattened data-memory debug bus; slot j occupies bits [(j+1)*SLOT_SIZE-1 : j*SLOT_SIZE].
REQ-007 The module SHALL have port i_tx_ready, input, 1 bit: byte sink can accept a byte.
REQ-008 The module SHALL have port o_tx_data, output, 8 bits: byte offered to the sink.
REQ-009 The module SHALL have port o_tx_valid, output, 1 bit: o_tx_data is valid.
REQ-010 The module SHALL have port o_busy, output, 1 bit: dump in progress.
REQ-011 The module SHALL have port o_done, output, 1 bit: one-cycle end-of-dump pulse.

Function
REQ-012 The module SHALL use an FSM with states IDLE, SEND and DONE.
REQ-013 In IDLE with i_start=1, the module SHALL snapshot i_bus_debug into an internal register on that edge, clear the slot and byte counters, and enter SEND.
REQ-014 In SEND, o_tx_valid SHALL be 1 and o_busy SHALL be 1; the first byte SHALL appear the cycle after the i_start edge.
REQ-015 A byte SHALL transfer on a rising edge where o_tx_valid=1 and i_tx_ready=1.
REQ-016 o_tx_data SHALL hold stable while o_tx_valid=1 and i_tx_ready=0.
REQ-017 Slots SHALL be sent in ascending order, 0 to 2**ADDR_SIZE-1; each slot SHALL be sent MSB byte first, SLOT_SIZE/8 bytes per slot.
REQ-018 The byte counter SHALL wrap to 0 and the slot counter SHALL increment after the last byte of a slot transfers.
REQ-019 Transfer of the last byte of the last slot SHALL move the FSM to DONE; the slot counter SHALL NOT wrap into a second pass.
REQ-020 In DONE, o_done SHALL be 1 for exactly one cycle, o_busy=0 and o_tx_valid=0; the FSM SHALL then return to IDLE.
REQ-021 i_start SHALL be ignored in SEND and DONE.
REQ-022 Changes on i_bus_debug after the snapshot SHALL NOT affect the bytes sent.
REQ-023 With the prefix disabled, a dump SHALL be exactly 2**ADDR_SIZE*SLOT_SIZE/8 transfers.

Reset
REQ-024 When i_reset=1 on a rising edge, the FSM SHALL go to IDLE and counters and snapshot SHALL clear, including mid-dump; pending bytes are discarded and o_done SHALL NOT pulse.
REQ-025 During and after reset, o_tx_data SHALL be 8'h00 and o_tx_valid, o_busy and o_done SHALL be 0.
REQ-026 If i_reset and i_start are both 1 on the same edge, reset SHALL win.

Configuration
REQ-027 The macro MEM_DUMP_ADDR_PREFIX_EN SHALL control the address prefix.
REQ-028 With MEM_DUMP_ADDR_PREFIX_EN defined, each slot SHALL be preceded by one byte holding the slot index zero-extended to 8 bits, giving (SLOT_SIZE/8+1) transfers per slot.
REQ-029 With MEM_DUMP_ADDR_PREFIX_EN undefined, no prefix bytes SHALL be sent and no prefix logic SHALL be synthesized.

Structure
REQ-030 The shared header mem_dump_sender.vh SHALL hold the default ADDR_SIZE/SLOT_SIZE macros, FSM state encodings and the byte width constant, with the same default values as the data memory header.
REQ-031 The module SHALL have no sub-module; byte selection SHALL be an indexed part-select of the snapshot register.

Verification
REQ-032 ADDR_SIZE=2, SLOT_SIZE=32, slots 0..3 = 11223344/55667788/99AABBCC/DDEEFF00, i_tx_ready held 1, pulse i_start -> 16 bytes 11,22,...,FF,00 on consecutive cycles, then o_done high for one cycle.
REQ-033 Same setup with i_tx_ready toggling 1-0-1-0 -> the same 16-byte sequence, o_tx_data stable during every ready=0 cycle, no byte lost or duplicated.
REQ-034 Change slot 0 to 0 one cycle after i_start -> the first four bytes are still 11,22,33,44.
REQ-035 Assert i_reset after byte 5 -> outputs zero the next cycle, no o_done pulse; a new i_start restarts the dump at byte 11.
REQ-036 Pulse i_start repeatedly during SEND -> exactly one 16-byte dump and exactly one o_done pulse.
REQ-037 With MEM_DUMP_ADDR_PREFIX_EN defined -> 20 bytes: 00,11,22,33,44,01,55,...,03,DD,EE,FF,00.

Source files
------------

// File: rtl/mem_dump_sender_pkg.sv
// Shared defaults and FSM encoding for mem_dump_sender (the data-memory geometry
// must match the data memory that feeds i_bus_debug).
package mem_dump_sender_pkg;

  localparam int unsigned DEFAULT_ADDR_SIZE = 5;
  localparam int unsigned DEFAULT_SLOT_SIZE = 32;
  localparam int unsigned BYTE_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/mem_dump_sender.sv
// Snapshots the flattened data-memory debug bus and streams it out byte-wise
// over a valid/ready sink. Optional per-slot index prefix: MEM_DUMP_ADDR_PREFIX_EN.
module mem_dump_sender
  import mem_dump_sender_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int unsigned SLOT_SIZE = DEFAULT_SLOT_SIZE
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0]   i_bus_debug,
  input  logic                                  i_tx_ready,
  output logic [BYTE_W-1:0]                     o_tx_data,
  output logic                                  o_tx_valid,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int unsigned TOTAL_W        = (2**ADDR_SIZE) * SLOT_SIZE;
  localparam int unsigned IDX_W          = $clog2(TOTAL_W);
  localparam int unsigned BYTES_PER_SLOT = SLOT_SIZE / BYTE_W;
  localparam int unsigned BCW            = $clog2(BYTES_PER_SLOT + 1);

`ifdef MEM_DUMP_ADDR_PREFIX_EN
  // Position 0 of each slot is the index prefix, data bytes follow.
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_SLOT);
`else
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_SLOT - 1);
`endif

  dump_state_t          state;
  logic [TOTAL_W-1:0]   snapshot;
  logic [ADDR_SIZE-1:0] slot_cnt;
  logic [BCW-1:0]       byte_cnt;
  logic [BCW-1:0]       data_byte;
  logic [IDX_W-1:0]     sel_base;
  logic [BYTE_W-1:0]    cur_byte;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    data_byte = byte_cnt;
`ifdef MEM_DUMP_ADDR_PREFIX_EN
    if (byte_cnt != '0) data_byte = byte_cnt - BCW'(1);
`endif
    // MSB byte of the slot goes first, so offset counts down from the top byte.
    sel_base = IDX_W'(slot_cnt) * IDX_W'(SLOT_SIZE)
             + IDX_W'(BCW'(BYTES_PER_SLOT - 1) - data_byte) * IDX_W'(BYTE_W);
    cur_byte = snapshot[sel_base +: BYTE_W];
`ifdef MEM_DUMP_ADDR_PREFIX_EN
    if (byte_cnt == '0) cur_byte = BYTE_W'(slot_cnt);
`endif
  end

  assign o_tx_data = (state == ST_SEND) ? cur_byte : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      // NOTE: the wide snapshot is cleared too; a reset must not leave old memory
      // contents reachable through the byte mux.
      snapshot   <= '0;
      slot_cnt   <= '0;
      byte_cnt   <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            snapshot   <= i_bus_debug;
            slot_cnt   <= '0;
            byte_cnt   <= '0;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_tx_ready) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (&slot_cnt) begin
                o_tx_valid <= 1'b0;
                o_busy     <= 1'b0;
                o_done     <= 1'b1;
                state      <= ST_DONE;
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          o_done <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
